// File: rtl/vga_pkg.sv
// Shared VGA framebuffer types and constants used by the pixel path between the drawers and the framebuffer RAM.
package vga_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_ADDR_W = 15;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  colour;
   } fb_pix_t;

   typedef enum logic [1:0] {
      PWQ_IDLE,
      PWQ_DRAIN,
      PWQ_DONE
   } pwq_state_t;

   // y*160 + x as two shifts and two adds.
   function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
      logic [FB_ADDR_W-1:0] yw;
      logic [FB_ADDR_W-1:0] xw;
      yw = {{(FB_ADDR_W-7){1'b0}}, y};
      xw = {{(FB_ADDR_W-8){1'b0}}, x};
      return (yw << 7) + (yw << 5) + xw;
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of framebuffer pixels; pointers carry one extra wrap bit so full and empty are distinct.
module pixel_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  fb_pix_t                  data_i,
   input  logic                     pop_i,
   output fb_pix_t                  data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   fb_pix_t     mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: nothing is read from it while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pixel_write_queue.sv
// Clips the drawers' pixel stream, queues on-screen pixels and writes them through the shared framebuffer port.
module pixel_write_queue #(
   parameter int DEPTH    = 16,
   parameter int SCREEN_W = vga_pkg::SCREEN_W,
   parameter int SCREEN_H = vga_pkg::SCREEN_H,
   parameter int ADDR_W   = vga_pkg::FB_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           in_x,
   input  logic [6:0]           in_y,
   input  logic [2:0]           in_colour,
   input  logic                 in_plot,
   output logic                 in_ready,
   input  logic                 in_done,
   input  logic                 clr,
   output logic                 fb_req,
   input  logic                 fb_grant,
   output logic                 fb_we,
   output logic [ADDR_W-1:0]    fb_addr,
   output logic [2:0]           fb_data,
   output logic                 out_done,
   output logic                 overflow,
   output logic [7:0]           drop_count,
   output logic [7:0]           clip_count,
   output vga_pkg::pwq_state_t  dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic               on_screen;
   logic               clip;
   logic               want;
   logic               push;
   logic               pop;
   logic               drop;
   logic               drain_now;
   logic               full;
   logic               empty;
   logic [CW-1:0]      count;
   vga_pkg::fb_pix_t   wr_pix;
   vga_pkg::fb_pix_t   head;

   logic               overflow_q, overflow_d;
   logic [7:0]         drop_q, drop_d;
   logic [7:0]         clip_q, clip_d;
   vga_pkg::pwq_state_t state_q, state_d;

   assign on_screen = (in_x < 8'(SCREEN_W)) && (in_y < 7'(SCREEN_H));
   assign clip      = in_plot & ~on_screen;
   assign want      = in_plot & on_screen;
   assign pop       = ~empty & fb_grant;
   // A full queue still accepts when its head leaves on the same edge.
   assign push      = want & (~full | pop);
   assign drop      = want & full & ~pop;

   assign wr_pix.addr   = vga_pkg::pix_addr(in_x, in_y);
   assign wr_pix.colour = in_colour;

   pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (wr_pix),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign in_ready = ~full;
   assign fb_req   = ~empty;
   assign fb_we    = fb_req & fb_grant;
   assign fb_addr  = empty ? '0 : ADDR_W'(head.addr);
   assign fb_data  = empty ? '0 : head.colour;

   // clr dominates any drop or clip on the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      drop_d     = drop_q;
      clip_d     = clip_q;
      if (clr) begin
         overflow_d = 1'b0;
         drop_d     = '0;
         clip_d     = '0;
      end else begin
         if (drop) overflow_d = 1'b1;
         if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         if (clip && clip_q != 8'hFF) clip_d = clip_q + 8'd1;
      end
   end

   // Queue is empty after this edge and nothing new arrives.
   assign drain_now = ~push & (empty | ((count == CW'(1)) & pop));

   always_comb begin
      state_d = state_q;
      case (state_q)
         vga_pkg::PWQ_IDLE:  if (in_done) state_d = vga_pkg::PWQ_DRAIN;
         vga_pkg::PWQ_DRAIN: if (drain_now) state_d = vga_pkg::PWQ_DONE;
         vga_pkg::PWQ_DONE: begin
            if (push)          state_d = vga_pkg::PWQ_DRAIN;
            else if (!in_done) state_d = vga_pkg::PWQ_IDLE;
         end
         default: state_d = vga_pkg::PWQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
         clip_q     <= '0;
         state_q    <= vga_pkg::PWQ_IDLE;
      end else begin
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         clip_q     <= clip_d;
         state_q    <= state_d;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign clip_count = clip_q;
   assign out_done   = (state_q == vga_pkg::PWQ_DONE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Bench for pixel_write_queue: directed scenarios plus random traffic against a queue-occupancy reference model.
module tb_pixel_write_queue;
  import vga_pkg::*;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic        in_done;
  logic        clr;
  logic        fb_req;
  logic        fb_grant;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        out_done;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [7:0]  clip_count;
  pwq_state_t  dbg_state;

  pixel_write_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_plot    (in_plot),
    .in_ready   (in_ready),
    .in_done    (in_done),
    .clr        (clr),
    .fb_req     (fb_req),
    .fb_grant   (fb_grant),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .out_done   (out_done),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clip_count (clip_count),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: occupancy, sticky flags and expected write stream
  logic [17:0] exp_q[$];
  int          model_cnt;
  int          m_clip;
  int          m_drop;
  int          m_ovf;
  int          total;
  int          bad;
  int          wr_count;
  int          last_addr;
  int          last_data;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_status(input string name);
    check({name, "_req"},   int'(fb_req),     int'(model_cnt > 0));
    check({name, "_ready"}, int'(in_ready),   int'(model_cnt < DEPTH));
    check({name, "_clip"},  int'(clip_count), m_clip);
    check({name, "_drop"},  int'(drop_count), m_drop);
    check({name, "_ovf"},   int'(overflow),   m_ovf);
  endtask

  // driver: apply one cycle of stimulus and advance the model across the edge
  task automatic cycle(input bit plot, input int x, input int y, input int c,
                       input bit grant, input bit clr_v);
    bit onscr;
    bit pop;
    in_plot   = plot;
    in_x      = x[7:0];
    in_y      = y[6:0];
    in_colour = c[2:0];
    fb_grant  = grant;
    clr       = clr_v;
    onscr = (x < 160) && (y < 120);
    pop   = grant && (model_cnt > 0);
    if (plot && !onscr) begin
      if (!clr_v && m_clip < 255) m_clip++;
    end else if (plot) begin
      if (model_cnt < DEPTH || pop) begin
        exp_q.push_back({15'(y * 160 + x), 3'(c)});
        model_cnt++;
      end else if (!clr_v) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (pop) model_cnt--;
    if (clr_v) begin
      m_clip = 0;
      m_drop = 0;
      m_ovf  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit grant);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, grant, 1'b0);
  endtask

  task automatic do_reset();
    in_plot  = 1'b0;
    fb_grant = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    model_cnt = 0;
    m_clip = 0;
    m_drop = 0;
    m_ovf  = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && fb_we) begin
      logic [17:0] exp;
      total++;
      wr_count++;
      last_addr = int'(fb_addr);
      last_data = int'(fb_data);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", fb_addr, fb_data);
      end else begin
        exp = exp_q.pop_front();
        if ({fb_addr, fb_data} !== exp) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   fb_addr, fb_data, exp[17:3], exp[2:0]);
        end
      end
    end
  end

  initial begin
    int base;
    total = 0; bad = 0; wr_count = 0; last_addr = -1; last_data = -1;
    in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0;
    in_done = 1'b0; clr = 1'b0; fb_grant = 1'b0; rst_n = 1'b0;
    do_reset();
    do_reset();

    // reset state
    check("rst_req",   int'(fb_req), 0);
    check("rst_we",    int'(fb_we), 0);
    check("rst_addr",  int'(fb_addr), 0);
    check("rst_data",  int'(fb_data), 0);
    check("rst_done",  int'(out_done), 0);
    check("rst_ovf",   int'(overflow), 0);
    check("rst_drop",  int'(drop_count), 0);
    check("rst_clip",  int'(clip_count), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_state", int'(dbg_state), int'(PWQ_IDLE));

    // single pixel, grant tied high
    base = wr_count;
    cycle(1'b1, 3, 2, 5, 1'b1, 1'b0);
    check("t1_req_next", int'(fb_req), 1);
    idle(3, 1'b1);
    check("t1_writes", wr_count - base, 1);
    check("t1_addr", last_addr, 323);
    check("t1_data", last_data, 5);
    check_status("t1");

    // clipping
    base = wr_count;
    cycle(1'b1, 160, 0, 1, 1'b1, 1'b0);
    check("t2_req_a", int'(fb_req), 0);
    cycle(1'b1, 0, 120, 2, 1'b1, 1'b0);
    check("t2_req_b", int'(fb_req), 0);
    idle(2, 1'b1);
    check("t2_clip", int'(clip_count), 2);
    check("t2_ovf", int'(overflow), 0);
    check("t2_writes", wr_count - base, 0);

    // backpressure
    base = wr_count;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, i, 10, i % 8, 1'b0, 1'b0);
      if (i == 14) check("t3_ready_15", int'(in_ready), 1);
    end
    check("t3_ready", int'(in_ready), 0);
    check("t3_ovf", int'(overflow), 1);
    check("t3_drop", int'(drop_count), 4);
    idle(20, 1'b1);
    check("t3_writes", wr_count - base, 16);
    check_status("t3");

    // clr pulse
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("clr_ovf", int'(overflow), 0);
    check("clr_drop", int'(drop_count), 0);
    check("clr_clip", int'(clip_count), 0);

    // clr coinciding with a clip
    cycle(1'b1, 200, 5, 0, 1'b0, 1'b1);
    check("clr_vs_clip", int'(clip_count), 0);

    // full queue with simultaneous pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 20 + i, 30, i % 8, 1'b0, 1'b0);
    check("t4_full", int'(in_ready), 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 50 + i, 40, (i + 3) % 8, 1'b1, 1'b0);
    check("t4_drop", int'(drop_count), 0);
    check("t4_ovf", int'(overflow), 0);
    check("t4_still_full", int'(in_ready), 0);
    idle(20, 1'b1);
    check_status("t4");

    // done drain
    for (int i = 0; i < 5; i++) cycle(1'b1, 100 + i, 60, i, 1'b0, 1'b0);
    in_done = 1'b1;
    idle(3, 1'b0);
    check("t5_not_done", int'(out_done), 0);
    base = wr_count;
    idle(4, 1'b1);
    check("t5_after4", int'(out_done), 0);
    idle(1, 1'b1);
    check("t5_writes", wr_count - base, 5);
    check("t5_done", int'(out_done), 1);
    cycle(1'b1, 7, 7, 3, 1'b0, 1'b0);
    check("t5_push_in_done", int'(out_done), 0);
    idle(1, 1'b1);
    check("t5_redone", int'(out_done), 1);
    in_done = 1'b0;
    idle(1, 1'b0);
    check("t5_release", int'(out_done), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, 200), $urandom_range(0, 127),
            $urandom_range(0, 7), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      check_status("rnd");
    end
    idle(20, 1'b1);
    check_status("rnd_end");

    // reset mid-frame
    for (int i = 0; i < 8; i++) cycle(1'b1, 10 + i, 11, i, 1'b0, 1'b0);
    check("t6_req_before", int'(fb_req), 1);
    do_reset();
    check("t6_req", int'(fb_req), 0);
    check("t6_clip", int'(clip_count), 0);
    check("t6_drop", int'(drop_count), 0);
    check("t6_ready", int'(in_ready), 1);
    base = wr_count;
    idle(5, 1'b1);
    check("t6_no_writes", wr_count - base, 0);

    // corner pixel
    cycle(1'b1, 159, 119, 6, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("corner_addr", last_addr, 19199);
    check("corner_data", last_data, 6);

    check("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
